adc_joiner: RTL and testbench
=============================

# adc_joiner

Receive-side counterpart of the two-channel DAC output path: accepts a single word-interleaved converter bus carrying channel A and channel B samples on alternate words, re-pairs them, converts the raw code format, optionally decimates by block averaging, and presents both channels as one aligned sample pair with a valid strobe. Sits between the converter capture pins (already in the `clk` domain) and the lockbox processing chain. It also reports sequence-error and overrange status to the register bank.

## Interface
- `DATA_WIDTH`, 14, sample width, in and out.
- `OFFSET_BINARY`, 1, 1 = raw words are offset binary (MSB inverted on conversion); 0 = already two's complement.
- `DEC_LOG2`, 0, decimation factor is 2^DEC_LOG2 pairs (0..6); output is the block average.
- `LOCK_PAIRS`, 4, consecutive good pairs required to assert `locked` (1..255).
- `clk` in 1 — sole clock. One clock; reset is asynchronous and active-low.
- `rst` in 1 — asynchronous, active-low reset (0 = reset).
- `din` in DATA_WIDTH — raw interleaved converter word.
- `din_sel` in 1 — 1 = `din` is channel A, 0 = channel B.
- `din_valid` in 1 — word qualifier; words with `din_valid`=0 are ignored.
- `clr` in 1 — single-cycle pulse; clears `err_cnt` and the sticky overrange flags.
- `dout_a`, `dout_b` out DATA_WIDTH — two's complement channel outputs, held between strobes.
- `dout_valid` out 1 — one-cycle strobe per output pair.
- `locked` out 1 — interleave alignment established.
- `err_cnt` out 16 — saturating sequence-error count.
- `ovr_a`, `ovr_b` out 1 — sticky overrange flags.

## Operation
- Input stage: `din`, `din_sel`, `din_valid` registered once; all logic below acts on the registered copy.
- Conversion: if OFFSET_BINARY, invert MSB; result is two's complement.
- Overrange: converted value == max positive (0x1FFF at 14 bits) or min negative (0x2000) sets the channel's sticky flag; a set event in the same cycle as `clr` wins (flag ends 1).
- Pairing FSM, states HUNT and HOLD_A:
  - HUNT + A word: store A, go HOLD_A.
  - HUNT + B word: sequence error, discard, stay HUNT.
  - HOLD_A + B word: pair complete, go HUNT.
  - HOLD_A + A word: sequence error, replace held A, stay HOLD_A.
  - Invalid words: no state change.
- Decimation: per-channel accumulators of width DATA_WIDTH+DEC_LOG2, sign-extended adds; on the 2^DEC_LOG2-th complete pair, output = (accumulator + current pair) arithmetic-shifted right by DEC_LOG2 (truncation toward −inf), accumulators and pair counter restart. DEC_LOG2=0: every pair is output directly.
- Sequence error: `err_cnt` += 1, saturating at 0xFFFF; `clr` in the same cycle loads 0 (clear wins). Also clears the decimation accumulators and pair counter, clears the good-pair counter and deasserts `locked`.
- Lock: good-pair counter increments per complete pair, saturating at LOCK_PAIRS; `locked` asserts when it reaches LOCK_PAIRS. Output pairs are emitted regardless of `locked`.

## Timing
- Reset (rst=0, asynchronous): `dout_a`=`dout_b`=0, `dout_valid`=0, `locked`=0, `err_cnt`=0, `ovr_a`=`ovr_b`=0; FSM HUNT; all counters/accumulators 0. Input registers cleared (valid=0). Release synchronously usable on the first `clk` edge after rst=1.
- Latency: B word completing a pair presented in cycle n → `dout_valid`=1 in cycle n+2, with `dout_a`/`dout_b` updated in that same cycle.
- `locked` rises in the same cycle as the `dout_valid` of the LOCK_PAIRS-th good pair; falls the cycle after the error word is registered (n+2 relative to the offending word).
- `err_cnt` and `ovr_*` update at n+2 relative to the causing word.
- Max throughput: one word per cycle, i.e. one pair every 2 cycles (DEC_LOG2=0).
- Reset mid-pair: held A discarded; no strobe results.

## Test plan
- OFFSET_BINARY=1, words A=0x2000,B=0x3FFF back to back -> `dout_valid` 2 cycles after B, `dout_a`=0x0000, `dout_b`=0x1FFF, `ovr_b`=1, `ovr_a`=0.
- Stream B,A,B,A,B,A,B,A,B -> `err_cnt`=1, 4 pairs output, `locked`=1 with the 4th pair's strobe.
- Locked stream then A,A -> `err_cnt` += 1, `locked`=0 two cycles after second A, second A is the one paired with the next B.
- DEC_LOG2=2, A samples (two's comp) 1,2,3,6 and B −1,−1,−1,−2 -> one strobe after 4th pair, `dout_a`=3, `dout_b`=−2 (0x3FFE).
- `din_valid` gaps of 3 cycles between A and B -> pair still formed, no error; `clr` pulsed with simultaneous error -> `err_cnt`=0.
- rst=0 asserted between A and B, then B,A,B -> one error counted, single pair output, all outputs 0 during reset.

Source files
------------

// File: rtl/adc_joiner.sv
// adc_joiner
//
// Receive side of the two-channel converter path. One bus carries channel A
// and channel B words in turn. This block pairs them up again and converts
// offset-binary codes to two's complement. It can also average blocks of
// 2^DEC_LOG2 pairs. Each finished pair comes out with a one-cycle valid
// strobe. Sequence errors and overrange events are reported for the
// register bank.
//
// Ports
//   clk        sole clock
//   rst        asynchronous reset, active low (0 = reset)
//   din        raw interleaved converter word
//   din_sel    1 = din is channel A, 0 = channel B
//   din_valid  word qualifier
//   clr        one-cycle pulse: clears err_cnt and the sticky overrange flags
//   dout_a/b   two's complement channel outputs, held between strobes
//   dout_valid one-cycle strobe per output pair
//   locked     alignment established (LOCK_PAIRS good pairs in a row)
//   err_cnt    saturating sequence-error count
//   ovr_a/b    sticky overrange flags
module adc_joiner #(
    parameter int DATA_WIDTH    = 14,
    parameter int OFFSET_BINARY = 1,
    parameter int DEC_LOG2      = 0,
    parameter int LOCK_PAIRS    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_sel,
    input  logic                  din_valid,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] dout_a,
    output logic [DATA_WIDTH-1:0] dout_b,
    output logic                  dout_valid,
    output logic                  locked,
    output logic [15:0]           err_cnt,
    output logic                  ovr_a,
    output logic                  ovr_b
);

    localparam int AW = DATA_WIDTH + DEC_LOG2;
    localparam int CW = DEC_LOG2 + 1;
    localparam logic [CW-1:0]         LAST_PAIR   = CW'((1 << DEC_LOG2) - 1);
    localparam logic [7:0]            LOCK_TARGET = 8'(LOCK_PAIRS);
    localparam logic [DATA_WIDTH-1:0] MAX_POS     = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] MIN_NEG     = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic {HUNT, HOLD_A} pair_state_t;

    pair_state_t            state;
    logic [DATA_WIDTH-1:0]  din_q;
    logic                   sel_q;
    logic                   vld_q;
    logic [DATA_WIDTH-1:0]  held_a;
    logic signed [AW-1:0]   acc_a;
    logic signed [AW-1:0]   acc_b;
    logic [CW-1:0]          pair_cnt;
    logic [7:0]             good_cnt;

    logic [DATA_WIDTH-1:0]  conv;
    logic                   word_a;
    logic                   word_b;
    logic                   seq_err;
    logic                   pair_done;
    logic                   ovr_hit;
    logic signed [AW-1:0]   sum_a;
    logic signed [AW-1:0]   sum_b;
    logic signed [AW-1:0]   avg_a;
    logic signed [AW-1:0]   avg_b;

    // Decode the registered word. The block sums include the pair that is
    // just completing, so the last pair of a block needs no extra cycle.
    // The size casts sign-extend because their operands are signed.
    always_comb begin
        conv = din_q;
        if (OFFSET_BINARY != 0) begin
            conv[DATA_WIDTH-1] = ~din_q[DATA_WIDTH-1];
        end
        word_a    = vld_q & sel_q;
        word_b    = vld_q & ~sel_q;
        seq_err   = ((state == HUNT) && word_b) || ((state == HOLD_A) && word_a);
        pair_done = (state == HOLD_A) && word_b;
        ovr_hit   = (conv == MAX_POS) || (conv == MIN_NEG);
        sum_a     = acc_a + AW'(signed'(held_a));
        sum_b     = acc_b + AW'(signed'(conv));
        avg_a     = sum_a >>> DEC_LOG2;
        avg_b     = sum_b >>> DEC_LOG2;
    end

    // Input capture, pairing FSM, decimation, lock tracking and status.
    // A sequence error restarts the current decimation block and lock
    // qualification. A newly arriving A word always becomes the held A,
    // even when it replaces an unpaired A from an error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            din_q      <= '0;
            sel_q      <= 1'b0;
            vld_q      <= 1'b0;
            state      <= HUNT;
            held_a     <= '0;
            acc_a      <= '0;
            acc_b      <= '0;
            pair_cnt   <= '0;
            good_cnt   <= '0;
            dout_a     <= '0;
            dout_b     <= '0;
            dout_valid <= 1'b0;
            locked     <= 1'b0;
            err_cnt    <= '0;
            ovr_a      <= 1'b0;
            ovr_b      <= 1'b0;
        end else begin
            din_q      <= din;
            sel_q      <= din_sel;
            vld_q      <= din_valid;
            dout_valid <= 1'b0;

            if (clr) begin
                err_cnt <= '0;
            end else if (seq_err && (err_cnt != 16'hFFFF)) begin
                err_cnt <= err_cnt + 16'd1;
            end

            if (word_a && ovr_hit) begin
                ovr_a <= 1'b1;
            end else if (clr) begin
                ovr_a <= 1'b0;
            end
            if (word_b && ovr_hit) begin
                ovr_b <= 1'b1;
            end else if (clr) begin
                ovr_b <= 1'b0;
            end

            case (state)
                HUNT: begin
                    if (word_a) begin
                        held_a <= conv;
                        state  <= HOLD_A;
                    end
                end
                HOLD_A: begin
                    if (word_a) begin
                        held_a <= conv;
                    end else if (word_b) begin
                        state <= HUNT;
                    end
                end
                default: state <= HUNT;
            endcase

            if (seq_err) begin
                acc_a    <= '0;
                acc_b    <= '0;
                pair_cnt <= '0;
                good_cnt <= '0;
                locked   <= 1'b0;
            end else if (pair_done) begin
                if (good_cnt != LOCK_TARGET) begin
                    good_cnt <= good_cnt + 8'd1;
                    if ((good_cnt + 8'd1) == LOCK_TARGET) begin
                        locked <= 1'b1;
                    end
                end
                if (pair_cnt == LAST_PAIR) begin
                    dout_a     <= avg_a[DATA_WIDTH-1:0];
                    dout_b     <= avg_b[DATA_WIDTH-1:0];
                    dout_valid <= 1'b1;
                    acc_a      <= '0;
                    acc_b      <= '0;
                    pair_cnt   <= '0;
                end else begin
                    acc_a    <= sum_a;
                    acc_b    <= sum_b;
                    pair_cnt <= pair_cnt + CW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_adc_joiner.sv
// tb_adc_joiner
//
// Drives two adc_joiner instances from the same word stream. One has no
// decimation and the other averages blocks of four pairs. Expected pairs are
// computed word by word by a behavioural model. A monitor matches every
// output strobe against the model's queues. Each test task also checks
// status and boundary values inline.
module tb_adc_joiner;

    localparam int DEC1 = 2;
    localparam int LOCK = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] din = '0;
    logic        din_sel = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr = 1'b0;

    logic [13:0] dout_a0, dout_b0, dout_a1, dout_b1;
    logic        dout_valid0, dout_valid1, locked0, locked1;
    logic [15:0] err_cnt0, err_cnt1;
    logic        ovr_a0, ovr_b0, ovr_a1, ovr_b1;

    int checks = 0;
    int errors = 0;

    adc_joiner #(.DATA_WIDTH(14), .OFFSET_BINARY(1), .DEC_LOG2(0), .LOCK_PAIRS(LOCK)) u_dut0 (
        .clk(clk), .rst(rst), .din(din), .din_sel(din_sel), .din_valid(din_valid), .clr(clr),
        .dout_a(dout_a0), .dout_b(dout_b0), .dout_valid(dout_valid0), .locked(locked0),
        .err_cnt(err_cnt0), .ovr_a(ovr_a0), .ovr_b(ovr_b0)
    );

    adc_joiner #(.DATA_WIDTH(14), .OFFSET_BINARY(1), .DEC_LOG2(DEC1), .LOCK_PAIRS(LOCK)) u_dut1 (
        .clk(clk), .rst(rst), .din(din), .din_sel(din_sel), .din_valid(din_valid), .clr(clr),
        .dout_a(dout_a1), .dout_b(dout_b1), .dout_valid(dout_valid1), .locked(locked1),
        .err_cnt(err_cnt1), .ovr_a(ovr_a1), .ovr_b(ovr_b1)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit  m_have_a;
    int  m_held;
    int  m_good;
    int  m_err;
    bit  m_locked, m_ovr_a, m_ovr_b;
    int  m_sum_a[2], m_sum_b[2], m_n[2];
    int  q_a0[$], q_b0[$], q_a1[$], q_b1[$];
    bit  q_l0[$], q_l1[$];

    function automatic int floor_div(int s, int n);
        int q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    function automatic int dec_of(int i);
        return (i == 0) ? 0 : DEC1;
    endfunction

    task automatic model_reset();
        m_have_a = 0; m_held = 0; m_good = 0; m_err = 0;
        m_locked = 0; m_ovr_a = 0; m_ovr_b = 0;
        for (int i = 0; i < 2; i++) begin
            m_sum_a[i] = 0; m_sum_b[i] = 0; m_n[i] = 0;
        end
        q_a0.delete(); q_b0.delete(); q_l0.delete();
        q_a1.delete(); q_b1.delete(); q_l1.delete();
    endtask

    task automatic model_error();
        if (m_err < 65535) m_err = m_err + 1;
        m_good = 0;
        m_locked = 0;
        for (int i = 0; i < 2; i++) begin
            m_sum_a[i] = 0; m_sum_b[i] = 0; m_n[i] = 0;
        end
    endtask

    task automatic model_pair(int a, int b);
        int len;
        if (m_good < LOCK) m_good = m_good + 1;
        m_locked = (m_good == LOCK);
        for (int i = 0; i < 2; i++) begin
            m_sum_a[i] += a;
            m_sum_b[i] += b;
            m_n[i] += 1;
            len = 1 << dec_of(i);
            if (m_n[i] == len) begin
                if (i == 0) begin
                    q_a0.push_back(floor_div(m_sum_a[i], len));
                    q_b0.push_back(floor_div(m_sum_b[i], len));
                    q_l0.push_back(m_locked);
                end else begin
                    q_a1.push_back(floor_div(m_sum_a[i], len));
                    q_b1.push_back(floor_div(m_sum_b[i], len));
                    q_l1.push_back(m_locked);
                end
                m_sum_a[i] = 0; m_sum_b[i] = 0; m_n[i] = 0;
            end
        end
    endtask

    task automatic model_word(bit sel, logic [13:0] raw);
        int v;
        v = int'(raw) ^ 'h2000;
        if (v >= 8192) v = v - 16384;
        if (v == 8191 || v == -8192) begin
            if (sel) m_ovr_a = 1;
            else     m_ovr_b = 1;
        end
        if (sel) begin
            if (m_have_a) model_error();
            m_held = v;
            m_have_a = 1;
        end else if (!m_have_a) begin
            model_error();
        end else begin
            m_have_a = 0;
            model_pair(m_held, v);
        end
    endtask

    // ---------------- drivers ----------------
    task automatic send_raw(bit sel, logic [13:0] raw);
        @(posedge clk); #1;
        din = raw; din_sel = sel; din_valid = 1'b1;
        model_word(sel, raw);
    endtask

    task automatic send(bit sel, int v);
        logic [13:0] raw;
        raw = 14'(v) ^ 14'h2000;
        send_raw(sel, raw);
    endtask

    task automatic idle(int n);
        repeat (n) begin
            @(posedge clk); #1;
            din_valid = 1'b0;
            din = 14'($urandom);
            din_sel = 1'($urandom);
        end
    endtask

    // ---------------- strobe monitor ----------------
    always @(negedge clk) begin
        int ea, eb;
        bit el;
        if (rst && dout_valid0) begin
            checks++;
            if (q_a0.size() == 0) begin
                errors++;
                $display("[TB] FAIL strobe0: unexpected strobe a=%h b=%h", dout_a0, dout_b0);
            end else begin
                ea = q_a0.pop_front(); eb = q_b0.pop_front(); el = q_l0.pop_front();
                if (dout_a0 !== 14'(ea) || dout_b0 !== 14'(eb) || locked0 !== el) begin
                    errors++;
                    $display("[TB] FAIL pair0: got a=%h b=%h lock=%b, want a=%h b=%h lock=%b",
                             dout_a0, dout_b0, locked0, 14'(ea), 14'(eb), el);
                end
            end
        end
        if (rst && dout_valid1) begin
            checks++;
            if (q_a1.size() == 0) begin
                errors++;
                $display("[TB] FAIL strobe1: unexpected strobe a=%h b=%h", dout_a1, dout_b1);
            end else begin
                ea = q_a1.pop_front(); eb = q_b1.pop_front(); el = q_l1.pop_front();
                if (dout_a1 !== 14'(ea) || dout_b1 !== 14'(eb) || locked1 !== el) begin
                    errors++;
                    $display("[TB] FAIL pair1: got a=%h b=%h lock=%b, want a=%h b=%h lock=%b",
                             dout_a1, dout_b1, locked1, 14'(ea), 14'(eb), el);
                end
            end
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({dout_a0, dout_b0, dout_valid0, locked0, err_cnt0, ovr_a0, ovr_b0} !== '0 ||
            {dout_a1, dout_b1, dout_valid1, locked1, err_cnt1, ovr_a1, ovr_b1} !== '0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h/%h, want all zero",
                     {dout_a0, dout_b0, dout_valid0, locked0, err_cnt0, ovr_a0, ovr_b0},
                     {dout_a1, dout_b1, dout_valid1, locked1, err_cnt1, ovr_a1, ovr_b1});
        end
        rst = 1'b1;
    endtask

    task automatic test_basic();
        send_raw(1'b1, 14'h2000);
        send_raw(1'b0, 14'h3FFF);
        idle(1);
        @(negedge clk);
        checks++;
        if (dout_valid0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL early_strobe: got %b, want 0", dout_valid0);
        end
        @(negedge clk);
        checks++;
        if (dout_valid0 !== 1'b1 || dout_a0 !== 14'h0000 || dout_b0 !== 14'h1FFF) begin
            errors++;
            $display("[TB] FAIL latency: got v=%b a=%h b=%h, want v=1 a=0000 b=1fff",
                     dout_valid0, dout_a0, dout_b0);
        end
        checks++;
        if (ovr_b0 !== 1'b1 || ovr_a0 !== 1'b0 || ovr_b1 !== 1'b1 || ovr_a1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovr_flags: got a=%b b=%b, want a=0 b=1", ovr_a0, ovr_b0);
        end
        idle(2);
    endtask

    task automatic test_lock_stream();
        for (int i = 0; i < 9; i++) begin
            send(((i % 2) == 1), $urandom_range(0, 16000) - 8000);
        end
        idle(3);
        checks++;
        if (locked0 !== 1'b1 || locked1 !== 1'b1 || err_cnt0 !== 16'(m_err)) begin
            errors++;
            $display("[TB] FAIL lock_stream: got lock=%b/%b err=%0d, want lock=1 err=%0d",
                     locked0, locked1, err_cnt0, m_err);
        end
    endtask

    task automatic test_double_a();
        int y, z;
        y = $urandom_range(0, 16000) - 8000;
        z = $urandom_range(0, 16000) - 8000;
        send(1'b1, 1234);
        send(1'b1, y);
        idle(1);
        @(negedge clk);
        checks++;
        if (locked0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lock_hold: got %b, want 1", locked0);
        end
        @(negedge clk);
        checks++;
        if (locked0 !== 1'b0 || locked1 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL lock_drop: got %b/%b, want 0", locked0, locked1);
        end
        send(1'b0, z);
        idle(3);
        checks++;
        if (dout_a0 !== 14'(y) || dout_b0 !== 14'(z) || err_cnt0 !== 16'(m_err)) begin
            errors++;
            $display("[TB] FAIL second_a: got a=%h b=%h err=%0d, want a=%h b=%h err=%0d",
                     dout_a0, dout_b0, err_cnt0, 14'(y), 14'(z), m_err);
        end
    endtask

    task automatic test_decimate();
        int av[4] = '{1, 2, 3, 6};
        int bv[4] = '{-1, -1, -1, -2};
        send(1'b0, 77);
        for (int i = 0; i < 4; i++) begin
            send(1'b1, av[i]);
            send(1'b0, bv[i]);
        end
        idle(3);
        checks++;
        if (dout_a1 !== 14'd3 || dout_b1 !== 14'h3FFE) begin
            errors++;
            $display("[TB] FAIL decimate: got a=%h b=%h, want a=0003 b=3ffe", dout_a1, dout_b1);
        end
        checks++;
        if (q_a1.size() != 0 || q_a0.size() != 0) begin
            errors++;
            $display("[TB] FAIL dec_count: pending %0d/%0d, want 0/0", q_a0.size(), q_a1.size());
        end
    endtask

    task automatic test_gaps_clr();
        send(1'b1, 500);
        idle(3);
        send(1'b0, -500);
        idle(3);
        checks++;
        if (err_cnt0 !== 16'(m_err) || dout_a0 !== 14'(500) || dout_b0 !== 14'(-500)) begin
            errors++;
            $display("[TB] FAIL gap_pair: got a=%h b=%h err=%0d, want a=%h b=%h err=%0d",
                     dout_a0, dout_b0, err_cnt0, 14'(500), 14'(-500), m_err);
        end
        send(1'b0, 100);
        @(posedge clk); #1;
        din_valid = 1'b0;
        clr = 1'b1;
        m_err = 0; m_ovr_a = 0; m_ovr_b = 0;
        @(posedge clk); #1;
        clr = 1'b0;
        idle(2);
        checks++;
        if (err_cnt0 !== 16'd0 || err_cnt1 !== 16'd0 || ovr_b0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL clr_wins: got err=%0d/%0d ovr_b=%b, want 0/0 0",
                     err_cnt0, err_cnt1, ovr_b0);
        end
    endtask

    task automatic test_reset_mid_pair();
        send(1'b1, 321);
        @(posedge clk); #1;
        din_valid = 1'b0;
        rst = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({dout_a0, dout_b0, dout_valid0, locked0, err_cnt0, ovr_a0, ovr_b0} !== '0) begin
            errors++;
            $display("[TB] FAIL mid_reset: got %h, want 0",
                     {dout_a0, dout_b0, dout_valid0, locked0, err_cnt0, ovr_a0, ovr_b0});
        end
        rst = 1'b1;
        send(1'b0, 11);
        send(1'b1, 22);
        send(1'b0, 33);
        idle(3);
        checks++;
        if (err_cnt0 !== 16'd1 || q_a0.size() != 0 || dout_a0 !== 14'd22 || dout_b0 !== 14'd33) begin
            errors++;
            $display("[TB] FAIL after_reset: got err=%0d a=%h b=%h, want err=1 a=0016 b=0021",
                     err_cnt0, dout_a0, dout_b0);
        end
    endtask

    task automatic test_random();
        bit next_sel;
        logic [13:0] raw;
        next_sel = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            if ($urandom_range(0, 9) == 0) next_sel = ~next_sel;
            raw = 14'($urandom);
            if ($urandom_range(0, 19) == 0) raw = ($urandom_range(0, 1) == 1) ? 14'h3FFF : 14'h0000;
            send_raw(next_sel, raw);
            next_sel = ~next_sel;
        end
        idle(3);
        checks++;
        if ({err_cnt0, locked0, ovr_a0, ovr_b0} !== {16'(m_err), m_locked, m_ovr_a, m_ovr_b} ||
            {err_cnt1, locked1, ovr_a1, ovr_b1} !== {16'(m_err), m_locked, m_ovr_a, m_ovr_b}) begin
            errors++;
            $display("[TB] FAIL random_status: got err=%0d lock=%b ovr=%b%b, want err=%0d lock=%b ovr=%b%b",
                     err_cnt0, locked0, ovr_a0, ovr_b0, m_err, m_locked, m_ovr_a, m_ovr_b);
        end
        checks++;
        if (q_a0.size() != 0 || q_a1.size() != 0) begin
            errors++;
            $display("[TB] FAIL random_drain: pending %0d/%0d, want 0/0", q_a0.size(), q_a1.size());
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_lock_stream();
        test_double_a();
        test_decimate();
        test_gaps_clr();
        test_reset_mid_pair();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
